// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types for the command master: response codes, FSM states, default PROT.
package axil_pkg;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      WR_RESP = 3'd2,
      READ    = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } state_t;

endpackage

// File: rtl/axil_timeout_ctr.sv
// Watchdog counter for the command master; expired_c is high once the count reaches LIMIT-1.
module axil_timeout_ctr #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);

   localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable)
         cnt <= cnt + CNT_W'(1);
   end

   assign expired_c = (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master turning single-beat local commands into one outstanding write or read.
// Optional watchdog and timeout_sticky output enabled by AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master
   import axil_pkg::*;
#(
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 16
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                            M_AXI_ACLK,
   input  logic                            M_AXI_ARESET,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_we,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic                            rsp_we,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
   ,output logic                           timeout_sticky
`endif
);

   localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
   localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

   state_t          state, state_d;
   logic            cmd_ready_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
   logic            rsp_valid_d, rsp_we_d, aw_done, aw_done_d, w_done, w_done_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d, rdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic            we_q, we_d;
   resp_t           resp_q, resp_d;

   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_WDATA  = wdata_q;
   assign M_AXI_WSTRB  = wstrb_q;
   assign M_AXI_AWPROT = PROT_DEFAULT;
   assign M_AXI_ARPROT = PROT_DEFAULT;
   assign rsp_resp     = resp_q;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
   logic timeout_c, sticky_d, active_c;

   assign active_c = (state == WRITE) || (state == WR_RESP) ||
                     (state == READ)  || (state == RD_DATA);

   axil_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk       (M_AXI_ACLK),
      .rst       (M_AXI_ARESET),
      .clear     (state_d != state),
      .enable    (active_c),
      .expired_c (timeout_c)
   );

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) timeout_sticky <= 1'b0;
      else              timeout_sticky <= sticky_d;
   end
`endif

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state         <= IDLE;
         cmd_ready     <= 1'b0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_we        <= 1'b0;
         rsp_rdata     <= '0;
         resp_q        <= OKAY;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         we_q          <= 1'b0;
      end else begin
         state         <= state_d;
         cmd_ready     <= cmd_ready_d;
         M_AXI_AWVALID <= awvalid_d;
         M_AXI_WVALID  <= wvalid_d;
         M_AXI_BREADY  <= bready_d;
         M_AXI_ARVALID <= arvalid_d;
         M_AXI_RREADY  <= rready_d;
         rsp_valid     <= rsp_valid_d;
         rsp_we        <= rsp_we_d;
         rsp_rdata     <= rdata_d;
         resp_q        <= resp_d;
         aw_done       <= aw_done_d;
         w_done        <= w_done_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         we_q          <= we_d;
      end
   end

   always_comb begin
      state_d     = state;
      cmd_ready_d = cmd_ready;
      awvalid_d   = M_AXI_AWVALID;
      wvalid_d    = M_AXI_WVALID;
      bready_d    = M_AXI_BREADY;
      arvalid_d   = M_AXI_ARVALID;
      rready_d    = M_AXI_RREADY;
      rsp_valid_d = rsp_valid;
      rsp_we_d    = rsp_we;
      rdata_d     = rsp_rdata;
      resp_d      = resp_q;
      aw_done_d   = aw_done;
      w_done_d    = w_done;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      we_d        = we_q;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      sticky_d    = timeout_sticky;
`endif

      case (state)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready) begin
               cmd_ready_d = 1'b0;
               addr_d      = cmd_addr & ~AW'(3);
               wdata_d     = cmd_wdata;
               wstrb_d     = cmd_wstrb;
               we_d        = cmd_we;
               aw_done_d   = 1'b0;
               w_done_d    = 1'b0;
               if (cmd_we) begin
                  state_d   = WRITE;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = READ;
                  arvalid_d = 1'b1;
               end
            end
         end
         // AW and W retire independently; move on only once both flags are registered
         WRITE: begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done && w_done) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (M_AXI_BVALID && M_AXI_BREADY) begin
               bready_d    = 1'b0;
               resp_d      = resp_t'(M_AXI_BRESP);
               rdata_d     = '0;
               rsp_we_d    = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         READ: begin
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (M_AXI_RVALID && M_AXI_RREADY) begin
               rready_d    = 1'b0;
               resp_d      = resp_t'(M_AXI_RRESP);
               rdata_d     = M_AXI_RDATA;
               rsp_we_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      // Hung slave: abandon every channel and report SLVERR
      if (timeout_c && active_c) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         resp_d      = SLVERR;
         rdata_d     = '0;
         rsp_we_d    = we_q;
         rsp_valid_d = 1'b1;
         sticky_d    = 1'b1;
         state_d     = RSP;
      end
`endif
   end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a configurable-wait AXI4-Lite slave.
module tb_axil_cmd_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_we;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [15:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
   logic        timeout_sticky;
`endif

   int checks = 0;
   int errors = 0;

   int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;
   logic        cfg_ar_never = 1'b0;
   logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic [31:0] cfg_rdata = 32'h0;

   int          aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0;
   logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
   logic [15:0] awaddr_seen = 16'h0, araddr_seen = 16'h0;
   logic [31:0] wdata_seen = 32'h0;
   logic [3:0]  wstrb_seen = 4'h0;
   int          aw_trail = 0, w_trail = 0, ar_glitch = 0;

   logic        got_we;
   logic [31:0] got_rdata;
   logic [1:0]  got_resp;
   int          lat;
   int          s_aw, s_w, s_b, s_ar, s_awt, s_wt, s_gl;

   axil_cmd_master #(
      .C_M_AXI_DATA_WIDTH(32),
      .C_M_AXI_ADDR_WIDTH(16)
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      ,.TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .M_AXI_ACLK   (clk),
      .M_AXI_ARESET (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_we       (cmd_we),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .cmd_wstrb    (cmd_wstrb),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_we       (rsp_we),
      .rsp_rdata    (rsp_rdata),
      .rsp_resp     (rsp_resp),
      .M_AXI_AWADDR (awaddr),
      .M_AXI_AWPROT (awprot),
      .M_AXI_AWVALID(awvalid),
      .M_AXI_AWREADY(awready),
      .M_AXI_WDATA  (wdata),
      .M_AXI_WSTRB  (wstrb),
      .M_AXI_WVALID (wvalid),
      .M_AXI_WREADY (wready),
      .M_AXI_BRESP  (bresp),
      .M_AXI_BVALID (bvalid),
      .M_AXI_BREADY (bready),
      .M_AXI_ARADDR (araddr),
      .M_AXI_ARPROT (arprot),
      .M_AXI_ARVALID(arvalid),
      .M_AXI_ARREADY(arready),
      .M_AXI_RDATA  (rdata),
      .M_AXI_RRESP  (rresp),
      .M_AXI_RVALID (rvalid),
      .M_AXI_RREADY (rready)
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      ,.timeout_sticky(timeout_sticky)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Handshake monitor
   always @(posedge clk) begin
      if (awvalid && awready) begin
         aw_beats    <= aw_beats + 1;
         aw_got      <= 1'b1;
         awaddr_seen <= awaddr;
      end
      if (wvalid && wready) begin
         w_beats    <= w_beats + 1;
         w_got      <= 1'b1;
         wdata_seen <= wdata;
         wstrb_seen <= wstrb;
      end
      if (bvalid && bready) begin
         b_beats <= b_beats + 1;
         aw_got  <= 1'b0;
         w_got   <= 1'b0;
      end
      if (arvalid && arready) begin
         ar_beats    <= ar_beats + 1;
         ar_got      <= 1'b1;
         araddr_seen <= araddr;
      end
      if (rvalid && rready)
         ar_got <= 1'b0;
   end

   // Slave: READYs after a programmable wait, B once AW and W are both taken, R after a wait
   initial begin : slave
      int aw_cnt, w_cnt, ar_cnt, r_cnt;
      logic ar_pv, ar_pr;
      logic [15:0] ar_pa;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      ar_pv = 1'b0; ar_pr = 1'b0; ar_pa = 16'h0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
      forever begin
         @(negedge clk);
         if (awvalid && !wvalid) aw_trail++;
         if (!awvalid && wvalid) w_trail++;
         if (ar_pv && !ar_pr && !rst && (!arvalid || araddr != ar_pa)) ar_glitch++;
         awready = awvalid && (aw_cnt >= cfg_aw_wait);
         aw_cnt  = awvalid ? aw_cnt + 1 : 0;
         wready  = wvalid && (w_cnt >= cfg_w_wait);
         w_cnt   = wvalid ? w_cnt + 1 : 0;
         bvalid  = aw_got && w_got;
         bresp   = cfg_bresp;
         arready = arvalid && !cfg_ar_never && (ar_cnt >= cfg_ar_wait);
         ar_cnt  = arvalid ? ar_cnt + 1 : 0;
         rvalid  = ar_got && (r_cnt >= cfg_r_wait);
         r_cnt   = ar_got ? r_cnt + 1 : 0;
         rdata   = cfg_rdata;
         rresp   = cfg_rresp;
         ar_pv = arvalid; ar_pr = arready; ar_pa = araddr;
      end
   end

   task automatic snap();
      s_aw = aw_beats; s_w = w_beats; s_b = b_beats; s_ar = ar_beats;
      s_awt = aw_trail; s_wt = w_trail; s_gl = ar_glitch;
   endtask

   task automatic run_cmd(input logic we, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("cmd_ready_bound", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) check("rsp_valid_bound", 32'(rsp_valid), 32'd1);
      got_we = rsp_we; got_rdata = rsp_rdata; got_resp = rsp_resp;
   endtask

   task automatic finish_rsp(input int hold, input logic [1:0] er, input logic [31:0] ed);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("rsp_hold_ctl", 32'({rsp_valid, cmd_ready, rsp_resp}), 32'({1'b1, 1'b0, er}));
         check("rsp_hold_rdata", rsp_rdata, ed);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin : main
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 16'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_handshakes", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
      check("rst_rsp", 32'({rsp_resp, rsp_we}), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_addr", 32'({awaddr, araddr}), 32'd0);
      check("prot", 32'({awprot, arprot}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

      // AWREADY two cycles ahead of WREADY
      cfg_aw_wait = 0; cfg_w_wait = 2; cfg_bresp = 2'b00;
      snap();
      run_cmd(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF);
      check("t1_resp", 32'(got_resp), 32'd0);
      check("t1_rdata", got_rdata, 32'd0);
      check("t1_we", 32'(got_we), 32'd1);
      check("t1_beats", 32'((aw_beats - s_aw) * 100 + (w_beats - s_w) * 10 + (b_beats - s_b)), 32'd111);
      check("t1_w_trail", 32'(w_trail - s_wt), 32'd2);
      check("t1_awaddr", 32'(awaddr_seen), 32'h0040);
      check("t1_wdata", wdata_seen, 32'hDEADBEEF);
      finish_rsp(0, 2'b00, 32'h0);

      // WREADY two cycles ahead of AWREADY
      cfg_aw_wait = 2; cfg_w_wait = 0;
      snap();
      run_cmd(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF);
      check("t2_resp", 32'(got_resp), 32'd0);
      check("t2_rdata", got_rdata, 32'd0);
      check("t2_beats", 32'((aw_beats - s_aw) * 100 + (w_beats - s_w) * 10 + (b_beats - s_b)), 32'd111);
      check("t2_aw_trail", 32'(aw_trail - s_awt), 32'd2);
      finish_rsp(0, 2'b00, 32'h0);

      // Simultaneous READYs, zero-wait slave
      cfg_aw_wait = 0; cfg_w_wait = 0;
      snap();
      run_cmd(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF);
      check("t3_resp", 32'(got_resp), 32'd0);
      check("t3_beats", 32'((aw_beats - s_aw) * 100 + (w_beats - s_w) * 10 + (b_beats - s_b)), 32'd111);
      check("t3_trails", 32'((aw_trail - s_awt) + (w_trail - s_wt)), 32'd0);
      check("t3_latency", 32'(lat), 32'd4);
      finish_rsp(0, 2'b00, 32'h0);

      // Read with AR wait and three R wait states
      cfg_ar_wait = 2; cfg_r_wait = 3; cfg_rdata = 32'h12345678; cfg_rresp = 2'b00;
      snap();
      run_cmd(1'b0, 16'h0044, 32'h0, 4'h0);
      check("t4_rdata", got_rdata, 32'h12345678);
      check("t4_we", 32'(got_we), 32'd0);
      check("t4_resp", 32'(got_resp), 32'd0);
      check("t4_ar_stable", 32'(ar_glitch - s_gl), 32'd0);
      check("t4_ar_beats", 32'(ar_beats - s_ar), 32'd1);
      check("t4_araddr", 32'(araddr_seen), 32'h0044);
      finish_rsp(0, 2'b00, 32'h12345678);

      // Partial strobe, SLVERR, consumer stalls five cycles
      cfg_bresp = 2'b10;
      run_cmd(1'b1, 16'h0048, 32'hA5A50F0F, 4'h3);
      check("t5_wstrb", 32'(wstrb_seen), 32'h3);
      check("t5_resp", 32'(got_resp), 32'd2);
      check("t5_rdata", got_rdata, 32'd0);
      finish_rsp(5, 2'b10, 32'h0);
      check("t5_released", 32'({rsp_valid, cmd_ready}), 32'b01);
      cfg_bresp = 2'b00;

      // Reset while ARVALID is pending
      cfg_ar_wait = 0; cfg_r_wait = 0; cfg_ar_never = 1'b1;
      @(negedge clk);
      check("t6_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0050;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_arvalid_held", 32'(arvalid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_arvalid_async", 32'(arvalid), 32'd0);
      check("t6_rst_outs", 32'({rsp_valid, cmd_ready}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cfg_ar_never = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_no_rsp", 32'(rsp_valid), 32'd0);
      cfg_rdata = 32'hCAFEF00D;
      run_cmd(1'b0, 16'h0046, 32'h0, 4'h0);
      check("t6_rdata", got_rdata, 32'hCAFEF00D);
      check("t6_araddr", 32'(araddr_seen), 32'h0044);
      check("t6_latency", 32'(lat), 32'd3);
      check("t6_resp", 32'(got_resp), 32'd0);
      finish_rsp(0, 2'b00, 32'hCAFEF00D);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      // ARREADY never arrives: watchdog fires after 16 cycles in READ
      check("t7_sticky_before", 32'(timeout_sticky), 32'd0);
      cfg_ar_never = 1'b1;
      run_cmd(1'b0, 16'h0060, 32'h0, 4'h0);
      check("t7_resp", 32'(got_resp), 32'd2);
      check("t7_rdata", got_rdata, 32'd0);
      check("t7_latency", 32'(lat), 32'd17);
      check("t7_arvalid", 32'(arvalid), 32'd0);
      check("t7_sticky", 32'(timeout_sticky), 32'd1);
      finish_rsp(0, 2'b10, 32'h0);
      cfg_ar_never = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
